// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one registered add/subtract unit among NREQ requesters.
// One operation in flight at a time. Results return on a single tagged response channel.
module addsub_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_result,
    output logic                    rsp_carry,
    output logic [15:0]             ops_done
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   lat_id;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic             lat_op;
    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH:0]   arith;

    // Requester index offset positions above base, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int unsigned offset);
        int unsigned pos;
        pos = 32'(base) + offset;
        return IDW'(pos % NREQ);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the search loop so no latch is inferred.
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid[rr_index(ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = rr_index(ptr, k);
            end
        end
    end

    // Accept depends only on state and req_valid, never on the response side.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // The top bit of the WIDTH+1 result is carry-out for add and borrow for subtract.
    always_comb begin
        if (lat_op) begin
            arith = {1'b0, lat_a} - {1'b0, lat_b};
        end else begin
            arith = {1'b0, lat_a} + {1'b0, lat_b};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            lat_id     <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        lat_a  <= req_a[grant_idx*WIDTH +: WIDTH];
                        lat_b  <= req_b[grant_idx*WIDTH +: WIDTH];
                        lat_op <= req_op[grant_idx];
                        lat_id <= grant_idx;
                        ptr    <= rr_index(grant_idx, 1);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    {rsp_carry, rsp_result} <= arith;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: a transaction-level model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_addsub_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = $clog2(NREQ);
    localparam int MOD   = 1 << WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_op = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_carry;
    logic [15:0]           ops_done;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .ops_done(ops_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [NREQ-1:0] seen_ready = '0;

    typedef struct {int id; int res; int car; int cyc;} rsp_t;
    rsp_t rsp_q[$];
    int   grant_idx_q[$];
    int   grant_cyc_q[$];

    // Model: at most one operation in flight, response visible two cycles after accept.
    bit          m_busy = 1'b0;
    int          m_acc  = 0;
    int          m_ptr  = 0;
    int unsigned m_ops  = 0;
    int          m_id, m_res, m_car;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void ref_op(input int a, input int b, input bit sub, output int res, output int car);
        if (!sub) begin
            res = (a + b) % MOD;
            car = (a + b >= MOD) ? 1 : 0;
        end else begin
            res = (a + MOD - b) % MOD;
            car = (a < b) ? 1 : 0;
        end
    endfunction

    always @(negedge clk) begin
        int w;
        logic [NREQ-1:0] exp_ready;
        bit exp_valid;
        cyc++;
        check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                grant_idx_q.push_back(i);
                grant_cyc_q.push_back(cyc);
            end
        end
        if (rst) begin
            check("req_ready_in_reset", 32'(req_ready), 32'd0);
            m_busy = 1'b0;
            m_ptr  = 0;
            m_ops  = 0;
        end else begin
            w = -1;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
            end
            exp_ready = '0;
            if (w >= 0) exp_ready[w] = 1'b1;
            exp_valid = m_busy && (cyc - m_acc >= 2);
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            check("ops_done", 32'(ops_done), m_ops);
            if (exp_valid) begin
                check("rsp_id", 32'(rsp_id), m_id);
                check("rsp_result", 32'(rsp_result), m_res);
                check("rsp_carry", 32'(rsp_carry), m_car);
            end
            if (exp_valid && rsp_ready) begin
                m_busy = 1'b0;
                m_ops  = (m_ops + 1) % 65536;
            end else if (w >= 0) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_id   = w;
                ref_op(int'(req_a[w*WIDTH +: WIDTH]), int'(req_b[w*WIDTH +: WIDTH]), req_op[w], m_res, m_car);
                m_ptr  = (w + 1) % NREQ;
            end
        end
        if (rsp_valid && rsp_ready && !rst)
            rsp_q.push_back('{int'(rsp_id), int'(rsp_result), int'(rsp_carry), cyc});
    end

    task automatic step();
        @(negedge clk);
        seen_ready = req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_operands(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic op);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_op[i] = op;
    endtask

    task automatic issue(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic op);
        int t;
        set_operands(i, a, b, op);
        req_valid[i] = 1'b1;
        t = 0;
        do begin
            step();
            t++;
        end while (!seen_ready[i] && t < 20);
        check("grant_timeout", 32'(seen_ready[i]), 32'd1);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int n_before);
        int t;
        t = 0;
        while (rsp_q.size() == n_before && t < 40) begin
            step();
            t++;
        end
        check("rsp_timeout", 32'(rsp_q.size() > n_before), 32'd1);
    endtask

    task automatic check_rsp(input int n, input int id, input int res, input int car);
        if (rsp_q.size() > n) begin
            check("lit_rsp_id", rsp_q[n].id, id);
            check("lit_rsp_result", rsp_q[n].res, res);
            check("lit_rsp_carry", rsp_q[n].car, car);
        end else begin
            check("lit_rsp_present", 32'd0, 32'd1);
        end
    endtask

    initial begin
        int n, g, t;
        logic [15:0] ops_before;

        // Reset values
        repeat (2) step();
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_ops_done", 32'(ops_done), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);
        check("reset_rsp_carry", 32'(rsp_carry), 32'd0);
        rst = 1'b0;

        // Single add and its latency
        n = rsp_q.size();
        g = grant_cyc_q.size();
        issue(0, 8'h7F, 8'h01, 1'b0);
        wait_rsp(n);
        check_rsp(n, 0, 'h80, 0);
        if (rsp_q.size() > n && grant_cyc_q.size() > g)
            check("latency", rsp_q[n].cyc - grant_cyc_q[g], 32'd2);
        check("ops_done_first", 32'(ops_done), 32'd1);

        // Overflow and borrow
        n = rsp_q.size(); issue(1, 8'hFF, 8'h02, 1'b0); wait_rsp(n); check_rsp(n, 1, 'h01, 1);
        n = rsp_q.size(); issue(2, 8'h03, 8'h05, 1'b1); wait_rsp(n); check_rsp(n, 2, 'hFE, 1);
        n = rsp_q.size(); issue(3, 8'h05, 8'h03, 1'b1); wait_rsp(n); check_rsp(n, 3, 'h02, 0);
        check("ops_done_four", 32'(ops_done), 32'd4);

        // Contention from reset
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_operands(i, WIDTH'(i * 16 + 1), WIDTH'(i + 2), i[0]);
        req_valid = '1;
        repeat (2) step();
        g = grant_idx_q.size();
        rst = 1'b0;
        for (int c = 0; c < 18; c++) begin
            step();
            for (int i = 0; i < NREQ; i++)
                if (seen_ready[i]) set_operands(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end
        check("contention_grants", 32'(grant_idx_q.size() - g >= 5), 32'd1);
        if (grant_idx_q.size() - g >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check("contention_order", grant_idx_q[g + k], k % NREQ);
                if (k > 0) check("contention_spacing", grant_cyc_q[g + k] - grant_cyc_q[g + k - 1], 32'd3);
            end
        end
        req_valid = '0;
        repeat (6) step();

        // Skip and wrap
        n = rsp_q.size(); issue(2, 8'h10, 8'h20, 1'b0); wait_rsp(n);
        g = grant_idx_q.size();
        set_operands(1, 8'h11, 8'h01, 1'b1);
        set_operands(3, 8'h33, 8'h03, 1'b0);
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        t = 0;
        while ((req_valid[1] || req_valid[3]) && t < 30) begin
            step();
            t++;
            if (seen_ready[1]) req_valid[1] = 1'b0;
            if (seen_ready[3]) req_valid[3] = 1'b0;
        end
        check("skip_grants", 32'(grant_idx_q.size() - g), 32'd2);
        if (grant_idx_q.size() - g >= 2) begin
            check("skip_first", grant_idx_q[g], 32'd3);
            check("skip_second", grant_idx_q[g + 1], 32'd1);
        end
        repeat (6) step();

        // Backpressure in RESP
        rsp_ready = 1'b0;
        issue(0, 8'h40, 8'h30, 1'b1);
        t = 0;
        while (!rsp_valid && t < 10) begin
            step();
            t++;
        end
        ops_before = ops_done;
        set_operands(2, 8'h01, 8'h02, 1'b0);
        req_valid[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_id", 32'(rsp_id), 32'd0);
            check("bp_rsp_result", 32'(rsp_result), 32'h10);
            check("bp_rsp_carry", 32'(rsp_carry), 32'd0);
            check("bp_ops_done", 32'(ops_done), 32'(ops_before));
            step();
            check("bp_req_ready", 32'(seen_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_release", 32'(ops_done), 32'(ops_before + 16'd1));
        t = 0;
        while (!seen_ready[2] && t < 10) begin
            step();
            t++;
        end
        req_valid[2] = 1'b0;
        repeat (6) step();

        // Reset during CALC
        n = rsp_q.size(); issue(1, 8'h01, 8'h01, 1'b0); wait_rsp(n);
        issue(2, 8'h09, 8'h09, 1'b0);
        n = rsp_q.size();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_ops_done", 32'(ops_done), 32'd0);
        g = grant_idx_q.size();
        set_operands(0, 8'h02, 8'h02, 1'b0);
        set_operands(3, 8'h03, 8'h03, 1'b0);
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        t = 0;
        while ((req_valid[0] || req_valid[3]) && t < 30) begin
            step();
            t++;
            if (seen_ready[0]) req_valid[0] = 1'b0;
            if (seen_ready[3]) req_valid[3] = 1'b0;
        end
        if (grant_idx_q.size() > g) check("rst_first_grant", grant_idx_q[g], 32'd0);
        else check("rst_first_grant_present", 32'd0, 32'd1);
        if (rsp_q.size() > n) check("rst_discarded", rsp_q[n].id, 32'd0);
        repeat (6) step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (seen_ready[i]) begin
                    req_valid[i] = 1'($urandom);
                    set_operands(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_operands(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
